updown_load_counter: RTL and testbench
======================================

Name: updown_load_counter

Overview:
- Parameterised synchronous up/down binary counter with an active-low parallel load and a count enable.
- Status flags report all-ones and zero states.
- General-purpose datapath/control building block: timers, address generators, event counters.
- Single clock domain; all state updates on rising clk edge.

Parameters:
- WIDTH, 4, bit width of count register, load data and count output (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- load_n  input  1  parallel load strobe, active-low
- up_down  input  1  direction: 1 = increment, 0 = decrement
- ce  input  1  count enable, active-high
- data_load  input  WIDTH  value loaded when load_n = 0
- count_out  output  WIDTH  current count, registered
- max_count  output  1  high when count_out equals all ones
- zero  output  1  high when count_out equals 0

Behaviour:
- One clock, clk; reset is synchronous and active-high (rst); no asynchronous paths.
- Priority per rising clk edge:
  1. rst = 1: count_out <= 0.
  2. Else load_n = 0: count_out <= data_load. Independent of ce and up_down.
  3. Else ce = 1 and up_down = 1: count_out <= count_out + 1.
  4. Else ce = 1 and up_down = 0: count_out <= count_out - 1.
  5. Else: hold.
- Latency: one cycle; result visible after the edge on which inputs are sampled.
- Arithmetic is modulo 2^WIDTH (default build):
  - all-ones + 1 wraps to 0
  - 0 - 1 wraps to all-ones
- max_count = (count_out == {WIDTH{1'b1}}), zero = (count_out == 0).
  - Both flags decoded combinationally from the count register only, never from inputs.
  - Glitch-free relative to the registered count.
- Reset values: count_out = 0, zero = 1, max_count = 0.
- Reset mid-operation: rst overrides a simultaneous load or count on the same edge.
- Loading all ones sets max_count next cycle; loading 0 sets zero next cycle.
- WIDTH = 1: max_count and zero are complementary; both rules above still apply.
- No X propagation: count register must never hold X after the first reset edge.

Optional Feature:
- Macro COUNTER_SATURATE_EN.
- Defined:
  - Counting saturates: increment at all-ones holds all-ones; decrement at 0 holds 0.
  - Load and reset unaffected.
  - Additional output sat_hit (1 bit, registered) pulses high for one cycle when a count request is blocked by saturation; reset value 0.
- Undefined: modulo wrap-around as specified above; sat_hit port absent.

Test Plan (WIDTH = 4):
- Reset: rst=1 for one edge with load_n=0, data_load=9, ce=1 -> count_out=0, zero=1, max_count=0.
- Load priority: rst=0, load_n=0, data_load=4'hA, ce=1, up_down=1 -> count_out=10 next cycle; no increment applied.
- Count up and wrap: load 14, then load_n=1, ce=1, up_down=1 for 3 cycles:
  - count_out = 15 (max_count=1), then 0 (zero=1), then 1.
  - With COUNTER_SATURATE_EN: 15, 15, 15 and sat_hit=1 on cycles 2 and 3.
- Count down and wrap: load 1, ce=1, up_down=0 for 2 cycles:
  - count_out = 0 (zero=1), then 15 (max_count=1).
  - With COUNTER_SATURATE_EN: 0, 0, with sat_hit=1 on the second cycle.
- Hold: load 7, then ce=0, load_n=1, toggle up_down for 5 cycles -> count_out stays 7, both flags 0.
- Random regression: 4000 cycles of random rst/load_n/ce/up_down/data_load against a cycle-accurate model.
  - Check count_out, max_count and zero every negedge clk.
  - Zero mismatches required; coverage of wrap in both directions and load of 0 and 15.

Source files
------------

// File: rtl/updown_load_counter.sv
// Synchronous up/down counter with active-low parallel load, count enable and all-ones/zero flags.
// Define COUNTER_SATURATE_EN to saturate at the ends instead of wrapping and to add the sat_hit pulse.
module updown_load_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_n,
  input  logic             up_down,
  input  logic             ce,
  input  logic [WIDTH-1:0] data_load,
  output logic [WIDTH-1:0] count_out,
  output logic             max_count,
`ifdef COUNTER_SATURATE_EN
  output logic             sat_hit,
`endif
  output logic             zero
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ALL_ZERO = '0;

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;

`ifdef COUNTER_SATURATE_EN
  logic r_sat_hit;
  logic w_blocked;

  // True when the requested step would run past either end of the range.
  function automatic logic f_blocked(input logic [WIDTH-1:0] cnt, input logic up);
    return up ? (cnt == ALL_ONES) : (cnt == ALL_ZERO);
  endfunction

  function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] cnt, input logic up);
    if (f_blocked(cnt, up)) return cnt;
    return up ? cnt + 1'b1 : cnt - 1'b1;
  endfunction

  assign w_blocked = f_blocked(r_count, up_down);
`else
  // Modulo 2^WIDTH: the adder simply drops the carry/borrow.
  function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] cnt, input logic up);
    return up ? cnt + 1'b1 : cnt - 1'b1;
  endfunction
`endif

  assign w_next = f_step(r_count, up_down);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (!load_n) begin
      r_count <= data_load;
    end else if (ce) begin
      r_count <= w_next;
    end
  end

`ifdef COUNTER_SATURATE_EN
  // Pulses only for a count request that saturation swallowed; load and hold clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_hit <= 1'b0;
    end else begin
      r_sat_hit <= load_n && ce && w_blocked;
    end
  end

  assign sat_hit = r_sat_hit;
`endif

  // Flags decode the register only, so they are as clean as the register itself.
  assign count_out = r_count;
  assign max_count = (r_count == ALL_ONES);
  assign zero      = (r_count == ALL_ZERO);

endmodule

// File: tb/tb_updown_load_counter.sv
// Directed and random self-checking bench for updown_load_counter (WIDTH = 4).
// Honours COUNTER_SATURATE_EN the same way the design does.
module tb_updown_load_counter;

  localparam int W    = 4;
  localparam int MAXV = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_n = 1'b1;
  logic         up_down = 1'b1;
  logic         ce = 1'b0;
  logic [W-1:0] data_load = '0;
  logic [W-1:0] count_out;
  logic         max_count;
  logic         zero;
`ifdef COUNTER_SATURATE_EN
  logic         sat_hit;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  updown_load_counter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_n    (load_n),
    .up_down   (up_down),
    .ce        (ce),
    .data_load (data_load),
    .count_out (count_out),
    .max_count (max_count),
`ifdef COUNTER_SATURATE_EN
    .sat_hit   (sat_hit),
`endif
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Inputs are set at a negedge; one posedge later, results are sampled at the next negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_state(input string tag, input int c, input int mx, input int z);
    chk({tag, ".count"}, int'(count_out), c);
    chk({tag, ".max"},   int'(max_count), mx);
    chk({tag, ".zero"},  int'(zero), z);
  endtask

  task automatic do_load(input int v);
    load_n = 1'b0; data_load = W'(v); ce = 1'b0;
    step();
    load_n = 1'b1;
  endtask

  int  m;
  bit  m_sat;
  int  cov_up_end, cov_dn_end, cov_ld0, cov_ld15;

  initial begin
    @(negedge clk);

    // Reset overrides simultaneous load and count.
    rst = 1'b1; load_n = 1'b0; data_load = 4'd9; ce = 1'b1; up_down = 1'b1;
    step();
    chk_state("reset", 0, 0, 1);
`ifdef COUNTER_SATURATE_EN
    chk("reset.sat_hit", int'(sat_hit), 0);
`endif

    // Load beats count.
    rst = 1'b0; load_n = 1'b0; data_load = 4'hA; ce = 1'b1; up_down = 1'b1;
    step();
    chk_state("load_prio", 10, 0, 0);

    // Count up across the top.
    do_load(14);
    chk_state("load14", 14, 0, 0);
    ce = 1'b1; up_down = 1'b1;
    step();
    chk_state("up1", 15, 1, 0);
`ifdef COUNTER_SATURATE_EN
    chk("up1.sat_hit", int'(sat_hit), 0);
    step();
    chk_state("up2", 15, 1, 0);
    chk("up2.sat_hit", int'(sat_hit), 1);
    step();
    chk_state("up3", 15, 1, 0);
    chk("up3.sat_hit", int'(sat_hit), 1);
`else
    step();
    chk_state("up2", 0, 0, 1);
    step();
    chk_state("up3", 1, 0, 0);
`endif

    // Count down across the bottom.
    do_load(1);
    chk_state("load1", 1, 0, 0);
    ce = 1'b1; up_down = 1'b0;
    step();
    chk_state("dn1", 0, 0, 1);
`ifdef COUNTER_SATURATE_EN
    chk("dn1.sat_hit", int'(sat_hit), 0);
    step();
    chk_state("dn2", 0, 0, 1);
    chk("dn2.sat_hit", int'(sat_hit), 1);
`else
    step();
    chk_state("dn2", 15, 1, 0);
`endif

    // Hold with ce low while direction toggles.
    do_load(7);
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up_down = ~up_down;
      step();
      chk_state("hold", 7, 0, 0);
    end

    // Reset in the middle of counting.
    ce = 1'b1; up_down = 1'b1; rst = 1'b1;
    step();
    chk_state("mid_rst", 0, 0, 1);
    rst = 1'b0;

    // Random regression against an independent behavioural model.
    m = 0; m_sat = 1'b0;
    cov_up_end = 0; cov_dn_end = 0; cov_ld0 = 0; cov_ld15 = 0;
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      load_n    = ($urandom_range(0, 7) != 0);
      ce        = ($urandom_range(0, 3) != 0);
      up_down   = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0:       data_load = 4'd0;
        1:       data_load = 4'd15;
        default: data_load = W'($urandom_range(0, MAXV));
      endcase

      m_sat = 1'b0;
      if (rst) begin
        m = 0;
      end else if (!load_n) begin
        m = int'(data_load);
        if (m == 0) cov_ld0++;
        if (m == MAXV) cov_ld15++;
      end else if (ce && up_down) begin
        if (m == MAXV) begin
          cov_up_end++;
`ifdef COUNTER_SATURATE_EN
          m_sat = 1'b1;
`else
          m = 0;
`endif
        end else m = m + 1;
      end else if (ce) begin
        if (m == 0) begin
          cov_dn_end++;
`ifdef COUNTER_SATURATE_EN
          m_sat = 1'b1;
`else
          m = MAXV;
`endif
        end else m = m - 1;
      end

      step();
      chk_state("rand", m, (m == MAXV) ? 1 : 0, (m == 0) ? 1 : 0);
`ifdef COUNTER_SATURATE_EN
      chk("rand.sat_hit", int'(sat_hit), int'(m_sat));
`endif
    end
    rst = 1'b0;

    chk("cov_up_end", int'(cov_up_end > 0), 1);
    chk("cov_dn_end", int'(cov_dn_end > 0), 1);
    chk("cov_ld0",    int'(cov_ld0 > 0), 1);
    chk("cov_ld15",   int'(cov_ld15 > 0), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
